// File: rtl/update_unpacker.sv
// Gather-side update unpacker: splits 512-bit packed update words into 4-lane beats,
// bounded by the entry count recorded by the scatter packer.
module update_unpacker #(
    parameter int LANES        = 4,
    parameter int ENTRY_W      = 64,
    parameter int WORD_ENTRIES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [31:0]                       entry_count,
    input  logic [WORD_ENTRIES*ENTRY_W-1:0]   word_in,
    input  logic                              word_in_valid,
    output logic                              word_in_ready,
    output logic [LANES*ENTRY_W-1:0]          entry_out,
    output logic [LANES-1:0]                  entry_out_valid,
    input  logic                              entry_out_ready,
    output logic                              last_out,
    output logic                              done
);

    localparam int WORD_W = WORD_ENTRIES * ENTRY_W;
    localparam int BEAT_W = LANES * ENTRY_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISHED
    } state_t;

    state_t              state;
    logic [31:0]         remaining;
    logic [31:0]         words_left;
    logic [WORD_W-1:0]   buf_word;
    logic                buf_full;
    logic                half;

    logic                is_run;
    logic                out_free;
    logic                buf_final;
    logic                buf_drain;
    logic                accept;
    logic                load;
    logic                src_half;
    logic                src_final;
    logic [WORD_W-1:0]   src_word;
    logic [BEAT_W-1:0]   src_entries;
    logic [2:0]          take;
    logic [BEAT_W-1:0]   beat_data;
    logic [LANES-1:0]    beat_mask;
    logic                last_taken;
    logic [31:0]         words_needed;

    assign is_run     = (state == RUN);
    assign out_free   = (entry_out_valid == '0) || entry_out_ready;
    // A half is the buffer's final beat if it is the upper half or it exhausts the pass.
    assign buf_final  = (remaining <= 32'd4) || half;
    assign buf_drain  = is_run && buf_full && out_free && buf_final;
    assign word_in_ready = is_run && (words_left != '0) && (!buf_full || buf_drain);
    assign accept     = word_in_valid && word_in_ready;
    // With an empty buffer the lower half of an incoming word goes straight to the output.
    assign load       = is_run && out_free && (buf_full || accept);
    assign src_half   = buf_full ? half : 1'b0;
    assign src_word   = buf_full ? buf_word : word_in;
    assign src_final  = (remaining <= 32'd4) || src_half;
    assign src_entries = src_half ? src_word[WORD_W-1:BEAT_W] : src_word[BEAT_W-1:0];
    assign take       = (remaining >= 32'd4) ? 3'd4 : remaining[2:0];
    assign last_taken = (entry_out_valid != '0) && entry_out_ready && last_out;
    assign words_needed = {3'b000, entry_count[31:3]} + {31'd0, |entry_count[2:0]};

    always_comb begin
        beat_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < 32'(take))
                beat_data[k*ENTRY_W +: ENTRY_W] = src_entries[k*ENTRY_W +: ENTRY_W];
        end
    end

    always_comb begin
        beat_mask = '0;
        case (take)
            3'd1:    beat_mask = 4'b1000;
            3'd2:    beat_mask = 4'b1100;
            3'd3:    beat_mask = 4'b1110;
            3'd4:    beat_mask = 4'b1111;
            default: beat_mask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            remaining       <= '0;
            words_left      <= '0;
            buf_word        <= '0;
            buf_full        <= 1'b0;
            half            <= 1'b0;
            entry_out       <= '0;
            entry_out_valid <= '0;
            last_out        <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISHED: begin
                    if (start) begin
                        remaining  <= entry_count;
                        words_left <= words_needed;
                        buf_full   <= 1'b0;
                        half       <= 1'b0;
                        if (entry_count == '0) begin
                            state <= FINISHED;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        buf_word   <= word_in;
                        words_left <= words_left - 32'd1;
                        if (load && !buf_full) begin
                            buf_full <= !src_final;
                            half     <= 1'b1;
                        end else begin
                            buf_full <= 1'b1;
                            half     <= 1'b0;
                        end
                    end else if (load) begin
                        if (src_final)
                            buf_full <= 1'b0;
                        else
                            half <= 1'b1;
                    end

                    if (load) begin
                        entry_out       <= beat_data;
                        entry_out_valid <= beat_mask;
                        last_out        <= (remaining <= 32'd4);
                        remaining       <= remaining - {29'd0, take};
                    end else if (out_free) begin
                        entry_out_valid <= '0;
                        last_out        <= 1'b0;
                    end

                    if (last_taken) begin
                        state <= FINISHED;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_update_unpacker.sv
// Scoreboard bench for update_unpacker: expected beats derived from the flat entry list of each pass.
module tb_update_unpacker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  entry_count;
    logic [511:0] word_in;
    logic         word_in_valid;
    logic         word_in_ready;
    logic [255:0] entry_out;
    logic [3:0]   entry_out_valid;
    logic         entry_out_ready;
    logic         last_out;
    logic         done;

    always #5 clk = ~clk;

    update_unpacker #(.LANES(4), .ENTRY_W(64), .WORD_ENTRIES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .entry_count(entry_count),
        .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready),
        .entry_out(entry_out), .entry_out_valid(entry_out_valid),
        .entry_out_ready(entry_out_ready), .last_out(last_out), .done(done)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   mask;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [63:0]  ents[$];
    logic [511:0] words[$];
    int           total = 0;
    int           bad = 0;
    int           words_taken = 0;
    int           beats_seen = 0;
    int           cur_nwords = 0;
    bit           pass_active = 0;
    bit           stalled = 0;
    beat_t        held;

    // Monitor: pops the scoreboard on every accepted beat, checks hold under stall.
    always @(negedge clk) begin
        beat_t got;
        beat_t want;
        if (rst_n) begin
            got = '{data: entry_out, mask: entry_out_valid, last: last_out};
            if (stalled) begin
                total++;
                if (got != held) begin
                    bad++;
                    $display("FAIL hold got=%h want=%h", got, held);
                end
            end
            if (pass_active) begin
                total++;
                if (word_in_ready && words_taken >= cur_nwords) begin
                    bad++;
                    $display("FAIL extra_ready got=1 want=0 taken=%0d words=%0d", words_taken, cur_nwords);
                end
            end
            if (word_in_valid && word_in_ready) words_taken++;
            if (entry_out_valid != 4'b0 && entry_out_ready) begin
                total++;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat got=%h want=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got != want) begin
                        bad++;
                        $display("FAIL beat got=%h want=%h", got, want);
                    end
                end
            end
            stalled = (entry_out_valid != 4'b0) && !entry_out_ready;
            held = got;
        end else begin
            stalled = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic prep(input int c);
        logic [511:0] w;
        beat_t b;
        int nb;
        ents.delete();
        words.delete();
        for (int j = 0; j < c; j++) ents.push_back({$urandom, $urandom});
        for (int wi = 0; wi < (c + 7) / 8; wi++) begin
            w = '0;
            for (int e = 0; e < 8; e++)
                w[e*64 +: 64] = (wi*8 + e < c) ? ents[wi*8 + e] : {$urandom, $urandom};
            words.push_back(w);
        end
        nb = (c + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int k = 0; k < 4; k++) begin
                if (bi*4 + k < c) begin
                    b.data[k*64 +: 64] = ents[bi*4 + k];
                    b.mask[3-k] = 1'b1;
                end
            end
            b.last = (bi == nb - 1);
            exp_q.push_back(b);
        end
        words_taken = 0;
        beats_seen = 0;
        cur_nwords = (c + 7) / 8;
    endtask

    task automatic launch(input int c);
        @(posedge clk); #1;
        entry_count = c;
        start = 1'b1;
        pass_active = 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_cycle(input bit bp);
        word_in_valid = (words_taken < cur_nwords) && ($urandom_range(3) != 0);
        word_in = (words_taken < cur_nwords) ? words[words_taken] : '0;
        entry_out_ready = bp ? ($urandom_range(2) != 0) : 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input int c, input bit bp);
        int cyc;
        prep(c);
        launch(c);
        if (c == 0) check("zero_done", {63'd0, done}, 64'd1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            drive_cycle(bp);
            cyc++;
        end
        word_in_valid = 1'b0;
        entry_out_ready = 1'b1;
        check("done", {63'd0, done}, 64'd1);
        check("leftover_beats", 64'(exp_q.size()), 64'd0);
        check("words_taken", 64'(words_taken), 64'(cur_nwords));
        @(posedge clk); #1;
        check("idle_valid", {60'd0, entry_out_valid}, 64'd0);
        check("idle_last", {63'd0, last_out}, 64'd0);
        check("done_held", {63'd0, done}, 64'd1);
        pass_active = 0;
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        entry_count = '0;
        word_in = '0;
        word_in_valid = 1'b0;
        entry_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, word_in_ready}, 64'd0);
        check("rst_valid", {60'd0, entry_out_valid}, 64'd0);
        check("rst_data", 64'(|entry_out), 64'd0);
        check("rst_last", {63'd0, last_out}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;

        run_pass(8, 0);
        run_pass(3, 0);
        run_pass(13, 0);
        run_pass(16, 1);
        run_pass(0, 0);
        for (int p = 0; p < 25; p++) run_pass($urandom_range(1, 40), $urandom_range(1) == 1);
        run_pass(0, 1);
        run_pass(5, 1);

        // Reset in the middle of a 16-entry pass, right after the first beat.
        prep(16);
        launch(16);
        cyc = 0;
        while (beats_seen < 1 && cyc < 200) begin
            drive_cycle(0);
            cyc++;
        end
        check("first_beat_seen", 64'(beats_seen), 64'd1);
        rst_n = 1'b0;
        word_in_valid = 1'b0;
        pass_active = 0;
        @(posedge clk); #1;
        check("mid_rst_valid", {60'd0, entry_out_valid}, 64'd0);
        check("mid_rst_data", 64'(|entry_out), 64'd0);
        check("mid_rst_last", {63'd0, last_out}, 64'd0);
        check("mid_rst_ready", {63'd0, word_in_ready}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        run_pass(4, 0);
        run_pass(12, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
